sc_posjug2_register: RTL and testbench

- Holds player-2's position vector for the 8-bit board row.
- Feeds the posjug2 operand of player-2's position comparator, which compares it against row 0.
- Player occupies exactly one bit in the upper nibble [7:4]; the lower nibble is always zero.
- Converts left/right button levels into single-step or auto-repeat moves, and respawns the player after a collision with a lockout window.

---
 rtl/sc_posjug2_register_pkg.sv | 23 ++
 rtl/sc_posjug2_step.sv | 36 +++
 rtl/sc_posjug2_register.sv | 127 ++++++++++++
 tb/tb_sc_posjug2_register.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_posjug2_register_pkg.sv
// Shared types and constants for the player-2 position register.
package pkg_posjug2;

    localparam int unsigned POS_W  = 8;
    localparam int unsigned POS_HI = 7;
    localparam int unsigned POS_LO = 4;

    localparam logic [POS_W-1:0] START_POS_DEFAULT = 8'b0001_0000;

    typedef enum logic [1:0] {
        READY = 2'b00,
        HOLD  = 2'b01,
        LOCK  = 2'b10
    } state_t;

    // left shifts toward the high bit, right toward the low bit
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_t;

endpackage

// File: rtl/sc_posjug2_step.sv
// Saturating one-hot shifter confined to bits [HI:LO]; reusable for either player nibble.
module sc_posjug2_step
    import pkg_posjug2::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned HI        = 7,
    parameter int unsigned LO        = 4
) (
    input  logic [DATAWIDTH-1:0] pos,
    input  dir_t                 dir,
    output logic [DATAWIDTH-1:0] next_pos_c,
    output logic                 changed_c
);

    // Shift one step unless the player already sits on the edge bit in that direction.
    always_comb begin
        next_pos_c = pos;
        changed_c  = 1'b0;
        case (dir)
            DIR_LEFT: begin
                if (!pos[HI]) begin
                    next_pos_c = pos << 1;
                    changed_c  = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (!pos[LO]) begin
                    next_pos_c = pos >> 1;
                    changed_c  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sc_posjug2_register.sv
// Player-2 position register: button edge/auto-repeat moves, collision respawn and lockout.
module sc_posjug2_register
    import pkg_posjug2::*;
#(
    parameter int unsigned           DATAWIDTH    = 8,
    parameter logic [DATAWIDTH-1:0]  START_POS    = START_POS_DEFAULT,
    parameter int unsigned           REPEAT_DELAY = 25000000,
    parameter int unsigned           LOCK_CYCLES  = 50000000,
    parameter int unsigned           CNT_W        =
        $clog2((REPEAT_DELAY > LOCK_CYCLES) ? REPEAT_DELAY : LOCK_CYCLES) + 1
) (
    input  logic                 SC_RegPOSJUG2_CLOCK_50,
    input  logic                 SC_RegPOSJUG2_RESET_InLow,
    input  logic                 SC_RegPOSJUG2_left_InHigh,
    input  logic                 SC_RegPOSJUG2_right_InHigh,
    input  logic                 SC_RegPOSJUG2_hit_InHigh,
    output logic [DATAWIDTH-1:0] SC_RegPOSJUG2_posjug2_OutBUS,
    output logic                 SC_RegPOSJUG2_moved_OutHigh,
    output logic                 SC_RegPOSJUG2_locked_OutHigh
);

    state_t               state,    state_d;
    logic [CNT_W-1:0]     cnt,      cnt_d;
    logic [DATAWIDTH-1:0] pos,      pos_d;
    logic                 moved,    moved_d;
    logic                 locked_d;
    dir_t                 hold_dir, hold_dir_d;
    logic                 prev_req;

    logic                 req_c;
    dir_t                 cur_dir_c;
    logic [DATAWIDTH-1:0] step_pos_c;
    logic                 step_changed_c;

    // Both buttons pressed cancel each other out.
    assign req_c     = SC_RegPOSJUG2_left_InHigh ^ SC_RegPOSJUG2_right_InHigh;
    assign cur_dir_c = SC_RegPOSJUG2_left_InHigh ? DIR_LEFT : DIR_RIGHT;

    sc_posjug2_step #(
        .DATAWIDTH (DATAWIDTH),
        .HI        (POS_HI),
        .LO        (POS_LO)
    ) u_step (
        .pos        (pos),
        .dir        (req_c ? cur_dir_c : DIR_NONE),
        .next_pos_c (step_pos_c),
        .changed_c  (step_changed_c)
    );

    // Next-state, next-position and counter decisions for READY/HOLD/LOCK.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        pos_d      = pos;
        moved_d    = 1'b0;
        hold_dir_d = hold_dir;
        case (state)
            READY: begin
                if (SC_RegPOSJUG2_hit_InHigh) begin
                    pos_d   = START_POS;
                    cnt_d   = '0;
                    state_d = LOCK;
                end else if (req_c && !prev_req) begin
                    pos_d      = step_pos_c;
                    moved_d    = step_changed_c;
                    cnt_d      = '0;
                    hold_dir_d = cur_dir_c;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (SC_RegPOSJUG2_hit_InHigh) begin
                    pos_d   = START_POS;
                    cnt_d   = '0;
                    state_d = LOCK;
                end else if (!req_c || (cur_dir_c != hold_dir)) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                    pos_d   = step_pos_c;
                    moved_d = step_changed_c;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            LOCK: begin
                if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = READY;
            end
        endcase
        locked_d = (state_d == LOCK);
    end

    // State, counter and registered outputs; synchronous active-low reset.
    always_ff @(posedge SC_RegPOSJUG2_CLOCK_50) begin
        if (!SC_RegPOSJUG2_RESET_InLow) begin
            state    <= READY;
            cnt      <= '0;
            pos      <= START_POS;
            moved    <= 1'b0;
            SC_RegPOSJUG2_locked_OutHigh <= 1'b0;
            hold_dir <= DIR_NONE;
            prev_req <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            pos      <= pos_d;
            moved    <= moved_d;
            SC_RegPOSJUG2_locked_OutHigh <= locked_d;
            hold_dir <= hold_dir_d;
            prev_req <= req_c;
        end
    end

    assign SC_RegPOSJUG2_posjug2_OutBUS = pos;
    assign SC_RegPOSJUG2_moved_OutHigh  = moved;

endmodule

// File: tb/tb_sc_posjug2_register.sv
// Bench for sc_posjug2_register: directed vector table, then random stimulus vs a reference model.
module tb_sc_posjug2_register;

    localparam int unsigned RD = 4;
    localparam int unsigned LC = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left_in;
    logic       right_in;
    logic       hit_in;
    logic [7:0] posjug2;
    logic       moved;
    logic       locked;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sc_posjug2_register #(
        .DATAWIDTH    (8),
        .START_POS    (8'h10),
        .REPEAT_DELAY (RD),
        .LOCK_CYCLES  (LC)
    ) dut (
        .SC_RegPOSJUG2_CLOCK_50       (clk),
        .SC_RegPOSJUG2_RESET_InLow    (rst_n),
        .SC_RegPOSJUG2_left_InHigh    (left_in),
        .SC_RegPOSJUG2_right_InHigh   (right_in),
        .SC_RegPOSJUG2_hit_InHigh     (hit_in),
        .SC_RegPOSJUG2_posjug2_OutBUS (posjug2),
        .SC_RegPOSJUG2_moved_OutHigh  (moved),
        .SC_RegPOSJUG2_locked_OutHigh (locked)
    );

    typedef struct {
        logic       rn;
        logic       l;
        logic       r;
        logic       h;
        logic [7:0] pos;
        logic       mv;
        logic       lk;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: player as a bit index, lock and hold as elapsed-cycle ages.
    int m_idx;
    bit m_in_lock;
    int m_lock_age;
    bit m_holding;
    int m_hold_dir;
    int m_hold_age;
    bit m_prev;
    bit m_mv;

    task automatic check(input string name, input int row, input logic [7:0] p,
                         input logic mv, input logic lk);
        tests++;
        if (posjug2 !== p || moved !== mv || locked !== lk) begin
            fails++;
            $display("FAIL %s row %0d: got pos=%h moved=%b locked=%b, expected pos=%h moved=%b locked=%b",
                     name, row, posjug2, moved, locked, p, mv, lk);
        end
    endtask

    task automatic drive(input logic rn, input logic l, input logic r, input logic h);
        rst_n    = rn;
        left_in  = l;
        right_in = r;
        hit_in   = h;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rn, input logic l, input logic r, input logic h,
                       input logic [7:0] p, input logic mv, input logic lk);
        vec_t v;
        v.rn = rn; v.l = l; v.r = r; v.h = h; v.pos = p; v.mv = mv; v.lk = lk;
        vecs.push_back(v);
    endtask

    task automatic model_try_move(input int d);
        int n;
        n = m_idx + d;
        if (n >= 4 && n <= 7) begin
            m_idx = n;
            m_mv  = 1'b1;
        end
    endtask

    task automatic model_step(input logic rn, input logic l, input logic r, input logic h);
        bit req;
        int d;
        m_mv = 1'b0;
        if (!rn) begin
            m_idx = 4; m_in_lock = 0; m_holding = 0; m_prev = 0;
            m_lock_age = 0; m_hold_age = 0; m_hold_dir = 0;
            return;
        end
        req = (l != r);
        d   = l ? 1 : -1;
        if (m_in_lock) begin
            if (m_lock_age == int'(LC)) m_in_lock = 0;
            else m_lock_age++;
        end else if (h) begin
            m_idx = 4; m_in_lock = 1; m_lock_age = 1; m_holding = 0;
        end else if (m_holding) begin
            if (!req || d != m_hold_dir) begin
                m_holding = 0;
            end else begin
                m_hold_age++;
                if (m_hold_age == int'(RD)) begin
                    model_try_move(d);
                    m_hold_age = 0;
                end
            end
        end else if (req && !m_prev) begin
            model_try_move(d);
            m_holding = 1; m_hold_dir = d; m_hold_age = 0;
        end
        m_prev = req;
    endtask

    initial begin
        rst_n = 1'b0; left_in = 1'b0; right_in = 1'b0; hit_in = 1'b0;

        // rn, l, r, h, expected pos, moved, locked
        add(0,0,0,0, 8'h10,0,0);   // reset
        add(1,0,0,0, 8'h10,0,0);   // first cycle after release
        add(1,1,0,0, 8'h20,1,0);   // single left
        add(1,0,0,0, 8'h20,0,0);
        add(1,1,0,0, 8'h40,1,0);
        add(1,0,0,0, 8'h40,0,0);
        add(1,1,0,0, 8'h80,1,0);
        add(1,0,0,0, 8'h80,0,0);
        add(1,1,0,0, 8'h80,0,0);   // saturated left
        add(1,0,0,0, 8'h80,0,0);
        add(1,0,1,0, 8'h40,1,0);   // hold right: press+1
        add(1,0,1,0, 8'h40,0,0);
        add(1,0,1,0, 8'h40,0,0);
        add(1,0,1,0, 8'h40,0,0);
        add(1,0,1,0, 8'h20,1,0);   // press+5
        add(1,0,1,0, 8'h20,0,0);
        add(1,0,1,0, 8'h20,0,0);
        add(1,0,1,0, 8'h20,0,0);
        add(1,0,1,0, 8'h10,1,0);   // press+9
        add(1,0,1,0, 8'h10,0,0);
        add(1,0,1,0, 8'h10,0,0);
        add(1,0,1,0, 8'h10,0,0);
        add(1,0,1,0, 8'h10,0,0);   // repeat saturates, no pulse
        add(1,0,0,0, 8'h10,0,0);
        add(1,1,0,0, 8'h20,1,0);
        add(1,0,0,0, 8'h20,0,0);
        add(1,1,1,0, 8'h20,0,0);   // both high
        add(1,1,1,0, 8'h20,0,0);
        add(1,1,0,0, 8'h40,1,0);   // release right -> left edge
        add(1,0,0,0, 8'h40,0,0);
        add(1,1,0,1, 8'h10,0,1);   // hit beats left edge
        add(1,1,0,0, 8'h10,0,1);
        add(1,0,0,0, 8'h10,0,1);
        add(1,1,0,0, 8'h10,0,1);
        add(1,0,0,0, 8'h10,0,1);
        add(1,1,0,0, 8'h10,0,1);   // sixth locked cycle
        add(1,1,0,0, 8'h10,0,0);   // exit, left held: no move
        add(1,1,0,0, 8'h10,0,0);
        add(1,0,0,0, 8'h10,0,0);
        add(1,1,0,0, 8'h20,1,0);   // re-press
        add(1,0,0,0, 8'h20,0,0);
        add(1,0,0,1, 8'h10,0,1);   // enter lock
        add(1,0,0,0, 8'h10,0,1);
        add(0,0,0,0, 8'h10,0,0);   // reset mid-LOCK
        add(1,0,0,0, 8'h10,0,0);
        add(1,1,0,0, 8'h20,1,0);   // enter HOLD
        add(1,1,0,0, 8'h20,0,0);
        add(0,1,0,0, 8'h10,0,0);   // reset mid-HOLD
        add(1,1,0,0, 8'h20,1,0);   // cleared prev-request -> edge
        add(1,1,0,0, 8'h20,0,0);
        add(1,1,0,0, 8'h20,0,0);
        add(1,1,0,0, 8'h20,0,0);
        add(1,1,0,0, 8'h40,1,0);   // repeat timed from a cleared counter
        add(1,0,0,0, 8'h40,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rn, vecs[i].l, vecs[i].r, vecs[i].h);
            check("vec", i, vecs[i].pos, vecs[i].mv, vecs[i].lk);
        end

        // Random phase against the reference model.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rand_reset", 0, 8'(1 << m_idx), m_mv, m_in_lock);
        begin
            logic l, r, h, rn;
            l = 0; r = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 5) == 0) l = ~l;
                if ($urandom_range(0, 5) == 0) r = ~r;
                h  = ($urandom_range(0, 39) == 0);
                rn = ($urandom_range(0, 299) != 0);
                drive(rn, l, r, h);
                model_step(rn, l, r, h);
                check("rand", c, 8'(1 << m_idx), m_mv, m_in_lock);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
